// File: rtl/freq_meter.sv
// Gated rising-edge counter: counts synchronized edges of sig_in over a
// programmable window of clk cycles and reports the result with a done pulse.
module freq_meter #(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sig_edge;

    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  acc, acc_nx;
    logic              acc_ovf, acc_ovf_nx;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        acc_ovf_nx = acc_ovf;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    acc_nx     = '0;
                    acc_ovf_nx = 1'b0;
                    state_nx   = (gate_len != '0) ? S_MEASURE : S_DONE;
                end
            end
            S_MEASURE: begin
                // Saturate at all-ones; only an edge beyond that flags overflow.
                if (sig_edge) begin
                    if (&acc) acc_ovf_nx = 1'b1;
                    else      acc_nx     = acc + CNT_W'(1);
                end
                if (gate_cnt == GATE_W'(1)) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gate_cnt <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            acc_ovf <= acc_ovf_nx;
            if (state == S_IDLE && start)
                gate_cnt <= gate_len;
            else if (state == S_MEASURE)
                gate_cnt <= gate_cnt - GATE_W'(1);
            // Result registers load on DONE entry so they are valid with done.
            if (state_nx == S_DONE && state != S_DONE) begin
                count_q <= acc_nx;
                ovf_q   <= acc_ovf_nx;
            end
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule
